mult_div_unit: RTL and testbench

//  Iterative HI/LO execute unit in EX, consuming the ALU FUNCT code for

---
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// One result bit per cycle; the pipeline is held through stall_req while busy.
`default_nettype none

module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [5:0]    F_MTHI   = 6'h11;
    localparam logic [5:0]    F_MTLO   = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    a_q, a_d;
    logic            div_q, div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            w_ready, w_md, w_accept, w_mt_hi, w_mt_lo;
    logic            w_a_neg, w_b_neg;
    logic [W-1:0]    w_a_mag, w_b_mag, w_addend;
    logic [W:0]      w_mul_sum, w_rem_sh, w_diff;
    logic            w_qbit;
    logic [2*W-1:0]  w_mul_next, w_div_next, w_prod;
    logic [W-1:0]    w_quo, w_rem;

    assign w_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_md     = (funct[5:2] == 4'b0110);
    assign w_accept = start && !flush && w_ready && w_md;
    assign w_mt_hi  = start && !flush && w_ready && (funct == F_MTHI);
    assign w_mt_lo  = start && !flush && w_ready && (funct == F_MTLO);

    // funct[0] clear marks the signed variants (MULT, DIV)
    assign w_a_neg = !funct[0] && operand_1[W-1];
    assign w_b_neg = !funct[0] && operand_2[W-1];
    assign w_a_mag = w_a_neg ? -operand_1 : operand_1;
    assign w_b_mag = w_b_neg ? -operand_2 : operand_2;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in
    assign w_addend   = acc_q[0] ? b_q : {W{1'b0}};
    assign w_mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, acc_q[W-1:1]};

    // Restoring divide: remainder in the high half, quotient bits enter at the bottom
    assign w_rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign w_diff     = w_rem_sh - {1'b0, b_q};
    assign w_qbit     = !w_diff[W];
    assign w_div_next = {(w_qbit ? w_diff[W-1:0] : w_rem_sh[W-1:0]), acc_q[W-2:0], w_qbit};

    assign w_prod = neg_res_q ? -acc_q : acc_q;
    assign w_quo  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign w_rem  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        a_d       = a_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    acc_d     = {{W{1'b0}}, w_a_mag};
                    b_d       = w_b_mag;
                    a_d       = operand_1;
                    div_d     = funct[1];
                    neg_res_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                end else if (w_mt_hi) begin
                    hi_d = operand_1;
                end else if (w_mt_lo) begin
                    lo_d = operand_1;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? w_div_next : w_mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!div_q) begin
                        {hi_d, lo_d} = w_prod;
                    end else if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = w_quo;
                        hi_d = w_rem;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            a_q       <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            a_q       <= a_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign stall_req = w_accept || (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed stimulus against an arithmetic reference model.
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op1, op2;
    logic        flush;
    logic        stall_req, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // Model state: cycles left until commit, pending result, architectural HI/LO
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic        last_stall, last_done;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .operand_1(op1), .operand_2(op2), .flush(flush),
        .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_md(input logic [5:0] f);
        return (f >= 6'h18) && (f <= 6'h1B);
    endfunction

    function automatic void compute(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        rh = 0;
        rl = 0;
        case (f)
            6'h18: begin p = longint'(sa) * longint'(sb); {rh, rl} = p; end
            6'h19: begin p = {32'b0, a} * {32'b0, b}; {rh, rl} = p; end
            default: begin
                if (b == 0) begin
                    rl = 32'hFFFF_FFFF; rh = a;
                end else if (f == 6'h1B) begin
                    rl = a / b; rh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 0;
                end else begin
                    rl = sa / sb; rh = sa % sb;
                end
            end
        endcase
    endfunction

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (!rst) begin
            m_left = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            if (flush) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; nd = 1'b1; end
            end
        end else if (start && !flush) begin
            if (is_md(funct)) begin
                m_left = 33;
                compute(funct, op1, op2, p_hi, p_lo);
            end else if (funct == 6'h11) m_hi = op1;
            else if (funct == 6'h13) m_lo = op1;
        end
        m_done = nd;
    endtask

    // Called at a falling edge with inputs driven; checks, then advances one cycle
    task automatic step();
        logic exp_stall;
        #1;
        exp_stall = (m_left > 0) || (start && !flush && is_md(funct));
        chk("stall_req", {63'b0, stall_req}, {63'b0, exp_stall});
        chk("done", {63'b0, done}, {63'b0, m_done});
        chk("hi", {32'b0, hi}, {32'b0, m_hi});
        chk("lo", {32'b0, lo}, {32'b0, m_lo});
        last_stall = stall_req;
        last_done  = done;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Issues one mult/div and returns at the falling edge of its done cycle
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int stalls);
        int n;
        start = 1'b1; funct = f; op1 = a; op2 = b;
        stalls = 0;
        step();
        start = 1'b0;
        n = 0;
        while (!m_done && n < 40) begin
            step();
            if (last_stall) stalls++;
            n++;
        end
        if (!m_done) chk("op_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        logic [5:0] tbl [9];
        tbl = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20};
        return tbl[$urandom_range(0, 8)];
    endfunction

    initial begin
        int st;
        rst = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'h0; op1 = 0; op2 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        chk("reset_stall", {63'b0, stall_req}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // MULTU full-scale
        run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
        chk("multu_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'b0, lo}, 64'h1);
        chk("multu_stall_cycles", 64'(st), 64'd33);
        chk("multu_done", {63'b0, done}, 64'd1);

        // Signed multiply then back-to-back signed divide
        run_op(6'h18, -32'd3, 32'd5, st);
        chk("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'b0, lo}, 64'hFFFF_FFF1);
        run_op(6'h1A, -32'd7, 32'd2, st);
        chk("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);

        // Divide by zero and signed overflow
        run_op(6'h1B, 32'd100, 32'd0, st);
        chk("divu0_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        chk("divu0_hi", {32'b0, hi}, 64'd100);
        chk("divu0_stall_cycles", 64'(st), 64'd33);
        run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, st);
        chk("divovf_lo", {32'b0, lo}, 64'h8000_0000);
        chk("divovf_hi", {32'b0, hi}, 64'd0);
        step();
        step();

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; funct = 6'h11; op1 = 32'h1234;
        step();
        chk("mthi_stall", {63'b0, last_stall}, 64'd0);
        funct = 6'h13; op1 = 32'h5678;
        step();
        chk("mtlo_stall", {63'b0, last_stall}, 64'd0);
        start = 1'b0;
        step();
        chk("mt_hi", {32'b0, hi}, 64'h1234);
        chk("mt_lo", {32'b0, lo}, 64'h5678);

        // DIVU flushed at CALC cycle 10
        start = 1'b1; funct = 6'h1B; op1 = 32'd1000; op2 = 32'd7;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_stall", {63'b0, stall_req}, 64'd0);
        chk("flush_done", {63'b0, done}, 64'd0);
        chk("flush_hi", {32'b0, hi}, 64'h1234);
        chk("flush_lo", {32'b0, lo}, 64'h5678);
        @(negedge clk);
        repeat (40) step();

        // Asynchronous reset at CALC cycle 5
        start = 1'b1; funct = 6'h19; op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678;
        step();
        start = 1'b0;
        repeat (4) step();
        #2 rst = 1'b0;
        #1;
        chk("arst_hi", {32'b0, hi}, 64'd0);
        chk("arst_lo", {32'b0, lo}, 64'd0);
        chk("arst_stall", {63'b0, stall_req}, 64'd0);
        m_left = 0; m_hi = 0; m_lo = 0; m_done = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b1;
        step();
        run_op(6'h19, 32'd12345, 32'd6789, st);
        chk("post_rst_hi", {32'b0, hi}, 64'd0);
        chk("post_rst_lo", {32'b0, lo}, 64'h04FE_D79D);
        step();

        // Random traffic: ops, moves, ignored starts and occasional flushes
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 2) != 0);
            funct = pick_funct();
            op1   = pick_val();
            op2   = pick_val();
            step();
        end
        start = 1'b0; flush = 1'b0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
